// File: rtl/ex_trap_pkg.sv
// Shared types and helpers for the external-trap arbiter.
// Arbiter FSM states, source-count ceiling, lowest-set-bit search.
package ex_trap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } trap_state_e;

  localparam int EX_TRAP_SRC_MAX = 32;

  // Index of the lowest set bit, 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [EX_TRAP_SRC_MAX-1:0] vec);
    lowest_set = '0;
    for (int i = EX_TRAP_SRC_MAX - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/ex_trap_arb_if.sv
// Trap request handshake between the arbiter (master) and the core (slave).
interface ex_trap_arb_if #(
  parameter int ID_W = 3
);
  logic            core_ex_trap_valid;
  logic [ID_W-1:0] core_ex_trap_id;
  logic            core_ex_trap_ready;

  modport master (
    output core_ex_trap_valid,
    output core_ex_trap_id,
    input  core_ex_trap_ready
  );

  modport slave (
    input  core_ex_trap_valid,
    input  core_ex_trap_id,
    output core_ex_trap_ready
  );
endinterface

// File: rtl/ex_trap_sync.sv
// Single-bit synchroniser; emits a one-cycle rising-edge pulse (EDGE_DET=1)
// or the synchronised level (EDGE_DET=0).
module ex_trap_sync #(
  parameter int SYNC_STG = 2,
  parameter bit EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic evt_o
);

  logic [SYNC_STG-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STG-2:0], src_i};

  // NOTE: reset is in the sensitivity list (async assert); flop updates use <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  generate
    if (EDGE_DET) begin : g_edge
      logic hist_q, hist_d;

      always_comb hist_d = sync_q[SYNC_STG-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 1'b0;
        else     hist_q <= hist_d;
      end

      assign evt_o = sync_q[SYNC_STG-1] & ~hist_q;
    end else begin : g_level
      assign evt_o = sync_q[SYNC_STG-1];
    end
  endgenerate

endmodule

// File: rtl/ex_trap_arb.sv
// External-trap arbiter: synchronise sources, latch pending, grant lowest index.
// Define EX_TRAP_LEVEL_EN for level-sensitive sources (no latch, no clear-on-grant).
module ex_trap_arb
  import ex_trap_pkg::*;
#(
  parameter int SRC_NUM  = 8,
  parameter int ID_W     = $clog2(SRC_NUM),
  parameter int SYNC_STG = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] irq_src,
  input  logic [SRC_NUM-1:0] irq_en,
  output logic [SRC_NUM-1:0] irq_pend,
  ex_trap_arb_if.master      trap
);

`ifdef EX_TRAP_LEVEL_EN
  localparam bit EDGE_DET = 1'b0;
`else
  localparam bit EDGE_DET = 1'b1;
`endif

  logic [SRC_NUM-1:0]         evt;
  logic [SRC_NUM-1:0]         pend;
  logic [EX_TRAP_SRC_MAX-1:0] pend_ext;
  trap_state_e                state_q, state_d;
  logic [ID_W-1:0]            id_q, id_d;

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    ex_trap_sync #(
      .SYNC_STG (SYNC_STG),
      .EDGE_DET (EDGE_DET)
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .src_i (irq_src[i]),
      .evt_o (evt[i])
    );
  end

`ifdef EX_TRAP_LEVEL_EN
  assign pend = evt & irq_en;
`else
  logic [SRC_NUM-1:0] pend_q, pend_d, clr;

  always_comb begin
    for (int i = 0; i < SRC_NUM; i++) begin
      clr[i] = (state_q == REQ) && trap.core_ex_trap_ready && (id_q == ID_W'(i));
    end
    // Set is applied after clear so a fresh edge on the granted source survives.
    pend_d = (pend_q & ~clr) | (evt & irq_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend = pend_q;
`endif

  assign irq_pend = pend;
  assign pend_ext = EX_TRAP_SRC_MAX'(pend);

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (|pend) begin
          id_d    = ID_W'(lowest_set(pend_ext));
          state_d = REQ;
        end
      end
      REQ:     if (trap.core_ex_trap_ready) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign trap.core_ex_trap_valid = (state_q == REQ);
  assign trap.core_ex_trap_id    = id_q;

endmodule

// File: doc/ex_trap_arb.md
Name: ex_trap_arb

Overview:
- Upstream stage of the SoC external-trap interface.
- Collects up to SRC_NUM asynchronous board/bench interrupt lines and synchronises them.
- Latches rising edges as pending and picks the highest-priority pending source.
- Presents that source to the core through the core_ex_trap_valid/core_ex_trap_ready handshake, one request in flight at a time.

Parameters:
- SRC_NUM, 8: number of interrupt source lines, legal range 2..32.
- ID_W, $clog2(SRC_NUM): width of the source ID; derived, do not override.
- SYNC_STG, 2: synchroniser flop stages per source, legal range 2..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- irq_src  in  SRC_NUM  raw asynchronous interrupt lines.
- irq_en  in  SRC_NUM  per-source enable, quasi-static, synchronous to clk.
- core_ex_trap_valid  out  1  trap request to the core.
- core_ex_trap_id  out  ID_W  index of the requested source; stable while valid=1.
- core_ex_trap_ready  in  1  core acceptance.
- irq_pend  out  SRC_NUM  current pending vector, for debug/CSR mirror.

Behaviour:
- Reset (async assert, sync release): all sync flops, edge history, pending, FSM and outputs go to 0. Specifically valid=0, id=0, irq_pend=0, FSM=IDLE.
- Sync: each irq_src bit passes through SYNC_STG flops. An edge is detected as sync & ~sync_d.
- Pending set: pend[i] <= 1 on (edge[i] & irq_en[i]).
- Pending clear: pend[i] is cleared on grant of i.
- Set and clear of the same bit in the same cycle: set wins, so the new edge is kept.
- Clearing irq_en[i] does not clear an already-set pend[i]; it only blocks new sets.
- Latency: irq_src rise to valid=1 is SYNC_STG+2 cycles in IDLE (sync stages, edge/pend flop, REQ register).
- Priority: the lowest index wins. It is evaluated only in IDLE; once a request is issued the ID is frozen.
- FSM states:
  - IDLE: if |pend, latch id = lowest set index, drive valid=1 next cycle, go to REQ.
  - REQ: valid=1, id held. On ready=1, clear pend[id], drop valid next cycle, go to GAP. Without ready, stay in REQ indefinitely.
  - GAP: one dead cycle with valid=0, so the core sees a deasserted valid between traps. Then go to IDLE.
- Back-to-back: two sources pending produce two requests separated by exactly 2 cycles of valid=0 (GAP + IDLE arbitration).
- Handshake rules:
  - valid never drops without ready.
  - id never changes while valid=1.
  - ready seen while valid=0 is ignored.
- A new edge on the source currently in REQ re-sets pend in the same cycle it is cleared (set wins), so it is re-requested later. Edges are not counted: multiple edges while pending collapse to one.
- Reset mid-REQ: valid drops asynchronously and the pending request is lost.
- irq_pend reflects the registered pend vector with no extra delay.

Optional Feature:
- Macro: EX_TRAP_LEVEL_EN.
- Defined: sources are level-sensitive.
  - pend[i] = sync[i] & irq_en[i], combinational from the synchroniser, with no latch and no clear-on-grant.
  - A source still high after GAP is requested again.
  - Latency is SYNC_STG+1.
- Undefined: edge-latched behaviour as above.

Decomposition:
- Package ex_trap_pkg holds:
  - FSM enum (IDLE, REQ, GAP);
  - EX_TRAP_SRC_MAX = 32;
  - a function returning the lowest-set-bit index of a 32-bit vector.
- One sub-module, ex_trap_sync: a SYNC_STG-flop synchroniser plus rising-edge detector for a single bit, instantiated SRC_NUM times by generate.

Test Plan:
- Reset: assert rst mid-REQ with src 3 pending → valid=0, irq_pend=0 immediately; after release no request until a new edge.
- Single edge: irq_en=8'hFF, pulse irq_src[5] for 1 cycle → valid=1 at cycle SYNC_STG+2, id=5. With ready held 0 for 10 cycles, valid and id stay stable. Then ready=1 → valid=0 next cycle and irq_pend=0.
- Priority: raise irq_src[6] and irq_src[2] in the same cycle, ready always 1 → id=2 first, then id=6 after exactly 2 idle cycles.
- Mask: irq_en[4]=0 and pulse irq_src[4] → no valid for 50 cycles and irq_pend[4]=0. Then set irq_en[4]=1 → still no request, because the edge was already missed.
- Re-edge during REQ: src 1 in REQ, new edge on irq_src[1] arrives in the ready cycle → irq_pend[1]=1 afterwards, and a second request with id=1 follows after GAP.
- With EX_TRAP_LEVEL_EN: hold irq_src[0]=1 with ready always 1 → valid pulses every 3 cycles with id=0. Drop irq_src[0] → requests stop within SYNC_STG+1 cycles.
